// File: rtl/tritone_soc_pkg.sv
// Shared SoC constants and enums for the ternary data-memory subsystem.
// Words are 27 trits stored as 2-bit trit codes.
package tritone_soc_pkg;

    localparam int DMEM_DEPTH  = 2048;
    localparam int DMEM_ADDR_W = 12;
    localparam int WORD_W      = 54;

    typedef enum logic [1:0] {
        REQ_CPU = 2'd0,
        REQ_EXT = 2'd1,
        REQ_DMA = 2'd2
    } req_id_e;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/tritone_rr_pick.sv
// Combinational rotate-priority picker: returns a one-hot grant for the first
// requester found searching upward from i_ptr, wrapping at N.
module tritone_rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt
);

    function automatic logic [PTR_W-1:0] wrap_idx(input int v);
        return PTR_W'(v % N);
    endfunction

    // Walk from the farthest slot back toward i_ptr so the closest hit wins.
    always_comb begin
        o_gnt = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[wrap_idx(int'(i_ptr) + k)]) begin
                o_gnt                               = '0;
                o_gnt[wrap_idx(int'(i_ptr) + k)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tritone_dmem_arbiter.sv
// Single-port data-memory arbiter for CPU, debug and DMA requesters, with
// bounded burst locking and out-of-range address rejection.
//
// state  | meaning
// ARB    | round-robin among requesters, CPU first when fixed priority is set
// LOCKED | r_owner holds the port for at most MAX_BURST consecutive grants
module tritone_dmem_arbiter
    import tritone_soc_pkg::*;
#(
    parameter int NREQ           = 3,
    parameter int DATA_W         = WORD_W,
    parameter int ADDR_W         = DMEM_ADDR_W,
    parameter int DEPTH          = DMEM_DEPTH,
    parameter int MAX_BURST      = 8,
    parameter int CPU_FIXED_PRIO = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NREQ-1:0]             i_req,
    input  logic [NREQ-1:0]             i_lock,
    input  logic [NREQ-1:0]             i_wr,
    input  logic [NREQ-1:0][ADDR_W-1:0] i_addr,
    input  logic [NREQ-1:0][DATA_W-1:0] i_wdata,
    output logic [NREQ-1:0]             o_gnt,
    output logic [NREQ-1:0]             o_rvalid,
    output logic                        o_rerr,
    output logic [DATA_W-1:0]           o_rdata,
    output logic                        o_mem_en,
    output logic                        o_mem_we,
    output logic [ADDR_W-2:0]           o_mem_addr,
    output logic [DATA_W-1:0]           o_mem_wdata,
    input  logic [DATA_W-1:0]           i_mem_rdata,
    output logic [1:0]                  o_owner,
    output logic                        o_busy
);

    localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W  = $clog2(MAX_BURST + 1);
    localparam int CPU_ID = int'(REQ_CPU);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [PTR_W-1:0]  r_owner;
    logic [CNT_W-1:0]  r_burst_left;
    logic [NREQ-1:0]   r_rvalid;
    logic              r_rerr;
    logic              r_rd_pend;

    logic [NREQ-1:0]   w_owner_oh;
    logic              w_hold;
    logic              w_forced;
    logic              w_others;
    logic [NREQ-1:0]   w_req_arb;
    logic [NREQ-1:0]   w_rr_gnt;
    logic [NREQ-1:0]   w_gnt;
    logic [PTR_W-1:0]  w_gid;
    logic              w_any;
    logic              w_arb_path;
    logic              w_lock_start;
    logic [ADDR_W-1:0] w_addr_sel;
    logic              w_inrange;

    assign w_owner_oh = NREQ'(1) << r_owner;
    assign w_hold     = (r_state == LOCKED) && i_req[r_owner] && i_lock[r_owner];
    assign w_forced   = (r_burst_left == '0);
    assign w_others   = |(i_req & ~w_owner_oh);
    // On forced release the owner only competes when nobody else is asking.
    assign w_req_arb  = (w_hold && w_forced && w_others) ? (i_req & ~w_owner_oh) : i_req;

    tritone_rr_pick #(
        .N     (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_req (w_req_arb),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_rr_gnt)
    );

    always_comb begin
        w_arb_path = 1'b1;
        w_gnt      = '0;
        if (w_hold && !w_forced) begin
            w_arb_path = 1'b0;
            w_gnt      = w_owner_oh;
        end else if ((CPU_FIXED_PRIO != 0) && w_req_arb[CPU_ID]) begin
            w_gnt = NREQ'(1);
        end else begin
            w_gnt = w_rr_gnt;
        end
        if (i_rst) begin
            w_gnt = '0;
        end
        w_gid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_gid = PTR_W'(i);
            end
        end
    end

    assign w_any = |w_gnt;

    always_comb begin
        w_state_nxt  = r_state;
        w_lock_start = 1'b0;
        if (w_arb_path) begin
            w_state_nxt = ARB;
            if (w_any && i_lock[w_gid]) begin
                w_state_nxt  = LOCKED;
                w_lock_start = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ARB;
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_burst_left <= '0;
            r_rvalid     <= '0;
            r_rerr       <= 1'b0;
            r_rd_pend    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rvalid  <= w_gnt;
            r_rerr    <= w_any && !w_inrange;
            r_rd_pend <= w_any && w_inrange && !i_wr[w_gid];
            if (w_any) begin
                r_rr_ptr <= (int'(w_gid) == NREQ - 1) ? '0 : w_gid + PTR_W'(1);
                if (w_lock_start) begin
                    r_owner      <= w_gid;
                    r_burst_left <= CNT_W'(MAX_BURST - 1);
                end else if (!w_arb_path) begin
                    r_burst_left <= r_burst_left - CNT_W'(1);
                end
            end
        end
    end

    assign w_addr_sel  = i_addr[w_gid];
    assign w_inrange   = (32'(w_addr_sel) < 32'(DEPTH));

    assign o_gnt       = w_gnt;
    assign o_mem_en    = w_any && w_inrange;
    assign o_mem_we    = w_any && w_inrange && i_wr[w_gid];
    assign o_mem_addr  = w_addr_sel[ADDR_W-2:0];
    assign o_mem_wdata = i_wdata[w_gid];

    assign o_rvalid    = r_rvalid;
    assign o_rerr      = r_rerr;
    assign o_rdata     = r_rd_pend ? i_mem_rdata : '0;
    assign o_owner     = (r_state == LOCKED) ? 2'(r_owner) : 2'd0;
    assign o_busy      = (r_state == LOCKED) || (|r_rvalid);

endmodule

// File: tb/tb_tritone_dmem_arbiter.sv
// Scoreboard bench: two arbiters (CPU fixed priority on / off) share stimulus;
// a reference model predicts grants and queues responses for a monitor.
module tb_tritone_dmem_arbiter;

    localparam int DEPTH = 2048;
    localparam int MAXB  = 8;

    typedef struct {
        int          m;
        int          due;
        int          id;
        bit          rerr;
        logic [53:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_mem = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]       req_i = '0, lock_i = '0, wr_i = '0;
    logic [2:0][11:0] addr_i  = '0;
    logic [2:0][53:0] wdata_i = '0;
    logic [2:0]       nx_req, nx_lock, nx_wr;
    logic [2:0][11:0] nx_addr;
    logic [2:0][53:0] nx_wdata;

    logic [2:0]  gnt_o [2];
    logic [2:0]  rvalid_o [2];
    logic        rerr_o [2];
    logic [53:0] rdata_o [2];
    logic        men [2];
    logic        mwe [2];
    logic [10:0] maddr [2];
    logic [53:0] mwd [2];
    logic [53:0] mrd [2];
    logic [1:0]  owner_o [2];
    logic        busy_o [2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar m = 0; m < 2; m++) begin : g_dut
        tritone_dmem_arbiter #(
            .NREQ(3), .DATA_W(54), .ADDR_W(12), .DEPTH(DEPTH),
            .MAX_BURST(MAXB), .CPU_FIXED_PRIO((m == 0) ? 1 : 0)
        ) u_dut (
            .i_clk(clk), .i_rst(rst), .i_req(req_i), .i_lock(lock_i),
            .i_wr(wr_i), .i_addr(addr_i), .i_wdata(wdata_i),
            .o_gnt(gnt_o[m]), .o_rvalid(rvalid_o[m]), .o_rerr(rerr_o[m]),
            .o_rdata(rdata_o[m]), .o_mem_en(men[m]), .o_mem_we(mwe[m]),
            .o_mem_addr(maddr[m]), .o_mem_wdata(mwd[m]), .i_mem_rdata(mrd[m]),
            .o_owner(owner_o[m]), .o_busy(busy_o[m])
        );

        logic [53:0] mem [2048];
        always @(posedge clk) begin
            if (clr_mem) begin
                for (int i = 0; i < 2048; i++) mem[i] <= '0;
            end else if (men[m]) begin
                if (mwe[m]) mem[maddr[m]] <= mwd[m];
                else        mrd[m] <= mem[maddr[m]];
            end
        end
    end

    // Reference model state
    bit          fixed [2] = '{1'b1, 1'b0};
    bit          m_locked [2];
    bit          m_pend [2];
    int          m_owner [2];
    int          m_cnt [2];
    int          m_ptr [2];
    logic [53:0] mm [2][2048];
    exp_t        q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_locked[m] = 0; m_pend[m] = 0; m_owner[m] = 0; m_cnt[m] = 0; m_ptr[m] = 0;
        end
        q.delete();
    endtask

    task automatic model_cycle(input int m);
        logic [2:0] r;
        int         g;
        bit         hold;
        bit         inr;
        exp_t       e;
        r = req_i; g = -1; hold = 0;
        if (m_locked[m] && req_i[m_owner[m]] && lock_i[m_owner[m]]) begin
            if (m_cnt[m] < MAXB) begin
                g = m_owner[m]; hold = 1;
            end else if ((r & ~(3'b001 << m_owner[m])) != 3'b000) begin
                r[m_owner[m]] = 1'b0;
            end
        end
        if (g < 0) begin
            if (fixed[m] && r[0]) g = 0;
            else for (int k = 0; k < 3; k++)
                if (g < 0 && r[(m_ptr[m] + k) % 3]) g = (m_ptr[m] + k) % 3;
        end
        chk($sformatf("gnt[%0d]", m), gnt_o[m], (g < 0) ? 0 : (1 << g));
        chk($sformatf("owner[%0d]", m), owner_o[m], m_locked[m] ? m_owner[m] : 0);
        chk($sformatf("busy[%0d]", m), busy_o[m], (m_locked[m] || m_pend[m]) ? 1 : 0);
        inr = (g >= 0) && (addr_i[g] < DEPTH);
        chk($sformatf("mem_en[%0d]", m), men[m], inr);
        if (inr) begin
            chk($sformatf("mem_we[%0d]", m), mwe[m], wr_i[g]);
            chk($sformatf("mem_addr[%0d]", m), maddr[m], addr_i[g]);
            if (wr_i[g]) chk($sformatf("mem_wdata[%0d]", m), mwd[m], wdata_i[g]);
        end
        m_pend[m] = (g >= 0);
        if (g >= 0) begin
            e.m = m; e.due = cyc + 1; e.id = g; e.rerr = !inr; e.rdata = '0;
            if (inr) begin
                if (wr_i[g]) mm[m][addr_i[g]] = wdata_i[g];
                else         e.rdata = mm[m][addr_i[g]];
            end
            q.push_back(e);
            m_ptr[m] = (g + 1) % 3;
            if (hold) m_cnt[m]++;
            else if (lock_i[g]) begin
                m_locked[m] = 1; m_owner[m] = g; m_cnt[m] = 1;
            end else m_locked[m] = 0;
        end else begin
            m_locked[m] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        req_i = nx_req; lock_i = nx_lock; wr_i = nx_wr; addr_i = nx_addr; wdata_i = nx_wdata;
        #1;
        model_cycle(0);
        model_cycle(1);
    endtask

    task automatic set_idle();
        nx_req = '0; nx_lock = '0; nx_wr = '0; nx_addr = '0; nx_wdata = '0;
    endtask

    task automatic apply_reset(input bit check_zero);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        if (check_zero) begin
            for (int m = 0; m < 2; m++) begin
                chk("rst_gnt", gnt_o[m], 0);
                chk("rst_rvalid", rvalid_o[m], 0);
                chk("rst_rerr", rerr_o[m], 0);
                chk("rst_rdata", rdata_o[m], 0);
                chk("rst_owner", owner_o[m], 0);
                chk("rst_busy", busy_o[m], 0);
                chk("rst_mem_en", men[m], 0);
            end
        end
        repeat (2) @(posedge clk);
        #2;
        req_i = '0; lock_i = '0; wr_i = '0;
        rst = 1'b0;
    endtask

    function automatic logic [11:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return 12'(2040 + $urandom_range(0, 15));
        return 12'($urandom_range(0, 15));
    endfunction

    // Monitor: every cycle, compare the response lanes against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                if (q.size() > 0 && q[0].m == m && q[0].due == cyc) begin
                    e = q.pop_front();
                    chk($sformatf("rvalid[%0d]", m), rvalid_o[m], 3'b001 << e.id);
                    chk($sformatf("rerr[%0d]", m), rerr_o[m], e.rerr);
                    chk($sformatf("rdata[%0d]", m), rdata_o[m], e.rdata);
                end else begin
                    chk($sformatf("rvalid_idle[%0d]", m), rvalid_o[m], 0);
                end
            end
        end
    end

    initial begin
        int mode;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 2048; i++) mm[m][i] = '0;
        model_reset();
        set_idle();
        repeat (3) @(posedge clk);
        #2;
        clr_mem = 1'b0;
        rst = 1'b0;

        // DMA write then read of address 5
        set_idle(); nx_req = 3'b100; nx_wr = 3'b100; nx_addr[2] = 12'd5; nx_wdata[2] = 54'h1;
        step();
        chk("t1_gnt_wr", gnt_o[0], 3'b100);
        nx_wr = 3'b000; nx_wdata[2] = '0;
        step();
        chk("t1_gnt_rd", gnt_o[1], 3'b100);
        set_idle(); step();

        // All requesting: pure round-robin vs CPU priority
        apply_reset(0);
        set_idle(); nx_req = 3'b111; nx_addr = {12'd3, 12'd2, 12'd1};
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t2_rr_order", gnt_o[1], 3'b001 << (k % 3));
            chk("t3_cpu_prio", gnt_o[0], 3'b001);
        end
        nx_req = 3'b110;
        step();
        chk("t3_after_cpu", gnt_o[0], 3'b010);
        set_idle(); step();

        // DMA locked burst of 12 against a waiting CPU
        set_idle(); nx_req = 3'b100; nx_lock = 3'b100; nx_wr = 3'b100;
        for (int k = 0; k < 8; k++) begin
            nx_addr[2] = 12'(100 + k); nx_wdata[2] = 54'(k + 1);
            step();
            chk("t4_burst", gnt_o[k % 2], 3'b100);
            if (k == 4) begin
                chk("t4_owner", owner_o[0], 2);
                chk("t4_busy", busy_o[1], 1);
            end
            nx_req = 3'b101;
        end
        step();
        chk("t4_cpu_fp", gnt_o[0], 3'b001);
        chk("t4_cpu_rr", gnt_o[1], 3'b001);
        nx_req = 3'b100;
        for (int k = 8; k < 12; k++) begin
            nx_addr[2] = 12'(100 + k); nx_wdata[2] = 54'(k + 1);
            step();
            chk("t4_relock", gnt_o[0], 3'b100);
        end
        set_idle(); step();

        // Out-of-range EXT read
        set_idle(); nx_req = 3'b010; nx_addr[1] = 12'd2048;
        step();
        chk("t5_gnt", gnt_o[0], 3'b010);
        chk("t5_mem_en", men[1], 0);
        set_idle(); step();

        // Reset right after a read grant drops the response
        set_idle(); nx_req = 3'b001; nx_addr[0] = 12'd5;
        step();
        apply_reset(1);
        set_idle(); nx_req = 3'b111;
        step();
        chk("t6_restart_rr", gnt_o[1], 3'b001);
        set_idle(); step();

        // Randomized traffic with streaming phases for EXT or DMA
        for (int seg = 0; seg < 40; seg++) begin
            mode = $urandom_range(0, 2);
            for (int c = 0; c < 50; c++) begin
                for (int i = 0; i < 3; i++) begin
                    nx_req[i]   = ($urandom_range(0, 99) < 50);
                    nx_lock[i]  = ($urandom_range(0, 99) < 25);
                    nx_wr[i]    = 1'($urandom_range(0, 1));
                    nx_addr[i]  = rand_addr();
                    nx_wdata[i] = 54'({$urandom(), $urandom()});
                end
                if (mode != 0) begin
                    nx_req[mode]  = ($urandom_range(0, 99) < 95);
                    nx_lock[mode] = ($urandom_range(0, 99) < 95);
                end
                step();
            end
        end
        set_idle();
        step();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tritone_dmem_arbiter.md
Name: tritone_dmem_arbiter

Overview:
Arbitrates the single-port SoC data memory (2048 x 27-trit words) between three requesters: CPU load/store (id 0), external debug port (id 1) and TPU DMA (id 2).
- Per-requester req/gnt issue handshake; response follows one cycle after grant.
- Round-robin arbitration with optional fixed CPU priority.
- Bounded burst lock for DMA streams.
- Out-of-range address rejection.
- Sits between the requester-side format converters and the dmem array.

Parameters:
NREQ, 3, number of requesters (id 0 = CPU)
DATA_W, 54, word width (27 trits x 2-bit trit encoding)
ADDR_W, 12, binary word-address width
DEPTH, 2048, valid words; addr >= DEPTH is out of range
MAX_BURST, 8, max consecutive locked grants to one owner (>=1)
CPU_FIXED_PRIO, 1, 1 = requester 0 beats round-robin when no lock is held

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req  in  NREQ  request valid, per requester
lock  in  NREQ  request a locked burst, per requester; sampled only with req
wr  in  NREQ  1 = write, 0 = read
addr  in  NREQ x ADDR_W  word address
wdata  in  NREQ x DATA_W  write data
gnt  out  NREQ  one-hot grant; the transfer happens when req[i] & gnt[i]
rvalid  out  NREQ  one-hot response strobe, one cycle after grant (reads and writes)
rerr  out  1  out-of-range error; qualified by any rvalid
rdata  out  DATA_W  read data; qualified by rvalid of a read
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W-1  memory address, ADDR_W-1 bits wide (DEPTH-indexed)
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; 1-cycle latency after mem_en & !mem_we
owner  out  2  id of the current lock holder; 0 when no lock is held
busy  out  1  high in LOCKED state or while a response is pending

Behaviour:
- Reset (async, any time):
  - state = ARB, rr_ptr = 0, burst_cnt = 0.
  - rvalid = 0, rerr = 0, rdata = 0, owner = 0, busy = 0.
  - gnt = 0 and mem_en = 0 while rst is high.
  - An in-flight response is dropped and never delivered.
- Grant logic:
  - gnt is combinational from req and state. At most one grant per cycle.
  - A grant is issued every cycle any req is high, so back-to-back grants (including to the same requester) are allowed.
- ARB state:
  - If CPU_FIXED_PRIO && req[0], grant 0.
  - Else grant the first requesting id searching from rr_ptr upward, with wrap-around.
  - On grant g: rr_ptr <= (g+1) mod NREQ.
  - If lock[g], go to LOCKED with owner = g and burst_cnt = 1.
- LOCKED state:
  - While req[owner] && lock[owner] && burst_cnt < MAX_BURST: grant only owner, burst_cnt++. Other requesters stall, including CPU.
  - Owner drops req or lock: return to ARB and arbitrate normally in the same cycle.
  - burst_cnt == MAX_BURST: forced release.
    - Return to ARB with rr_ptr = owner+1.
    - The owner may regain the grant only if no other requester is active.
    - A re-lock starts a fresh burst.
  - The CPU never waits more than MAX_BURST+1 cycles.
- Issue cycle (grant to g):
  - In-range address: mem_en = 1, mem_we = wr[g], mem_addr = addr[g], mem_wdata = wdata[g].
  - addr[g] >= DEPTH: mem_en = 0; response carries rerr = 1.
- Response (next cycle):
  - rvalid[g] = 1 for exactly one cycle.
  - rdata = mem_rdata for an in-range read, else 0.
  - rerr registered from the issue cycle.
  - A new grant may be issued in the same cycle as a response.
- Simultaneous events:
  - CPU and DMA request in the same cycle with CPU_FIXED_PRIO = 1 and no lock: CPU wins.
  - With CPU_FIXED_PRIO = 0: the winner is set by rr_ptr.
- Write then read of the same address in consecutive grants returns the new data; the memory is write-first and the order is preserved.

Decomposition:
- Shared package tritone_soc_pkg holds:
  - DMEM_DEPTH, DMEM_ADDR_W, WORD_W constants
  - requester id enum: REQ_CPU = 0, REQ_EXT = 1, REQ_DMA = 2
  - arbiter state enum: ARB, LOCKED
- One natural sub-module: tritone_rr_pick, a combinational rotate-priority one-hot picker taking a request vector and a pointer.

Test Plan:
1. Reset, then DMA write addr 5 = 54'h1 followed by DMA read addr 5 -> gnt[2] on both cycles; rvalid[2] one cycle after each grant; read returns rdata = 54'h1, rerr = 0.
2. All three req held high, CPU_FIXED_PRIO = 0 -> grant order 0,1,2,0,1,2; each rvalid follows its grant by exactly 1 cycle.
3. CPU_FIXED_PRIO = 1, req = 3'b111 with no lock -> gnt = 001 every cycle; EXT/DMA are granted only after CPU drops req.
4. DMA locked burst of 12, CPU requesting, MAX_BURST = 8 -> 8 consecutive DMA grants; then a CPU grant; then DMA re-locks for the remaining 4; owner = 2 and busy = 1 during the burst.
5. EXT read addr 2048 -> gnt[1] with mem_en = 0; next cycle rvalid[1] = 1, rerr = 1, rdata = 0.
6. Assert rst the cycle after a read grant -> rvalid never pulses; all outputs are 0 immediately (async); after release, arbitration restarts from id 0.
